// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, types and nibble helpers for the display scan controller.
package disp_pkg;
    localparam int N_DIGITS = 8;
    localparam int N_PHASES = 16;
    typedef enum logic [1:0] {GAP, ON, OFF} scan_state_t;
    typedef logic [2:0] digit_idx_t;
    function automatic logic [3:0] nib(input logic [31:0] w, input digit_idx_t d);
        return w[{d, 2'b00} +: 4];
    endfunction
    function automatic logic upper_zero(input logic [31:0] w, input digit_idx_t d);
        return (w >> {d, 2'b00}) == 32'd0;
    endfunction
endpackage

// File: rtl/disp_scan_timebase.sv
// disp_scan_timebase: cycle/phase/digit counters with phase, slot and frame strobes.
module disp_scan_timebase #(
    parameter int PHASE_CYCLES = 6250,
    parameter int N_DIGITS = 8
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] phase,
    output logic [2:0] digit,
    output logic       phase_step,
    output logic       slot_end,
    output logic       frame_wrap
);
    import disp_pkg::*;
    localparam int PCW = PHASE_CYCLES > 1 ? $clog2(PHASE_CYCLES) : 1;
    logic [PCW-1:0] pc;
    assign phase_step = pc == PCW'(PHASE_CYCLES - 1);
    assign slot_end = phase_step && phase == 4'(N_PHASES - 1);
    assign frame_wrap = slot_end && digit == 3'(N_DIGITS - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0;
            phase <= 4'd0;
            digit <= 3'd0;
        end else begin
            pc <= phase_step ? '0 : pc + 1'b1;
            if (phase_step) phase <= phase + 4'd1;
            if (slot_end) digit <= digit + 3'd1;
        end
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 8-digit multiplexed display scan scheduler with PWM brightness,
// ghost gap, leading-zero blanking and frame-synchronous word updates.
module disp_scan_ctrl #(
    parameter int PHASE_CYCLES = 6250,
    parameter int N_DIGITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [7:0]  digit_en,
    input  logic        lz_suppress,
    input  logic [3:0]  bright,
    output logic [7:0]  anodes,
    output logic [3:0]  nibble,
    output logic [2:0]  digit_sel,
    output logic        frame_done
);
    import disp_pkg::*;
    logic [3:0] phase;
    logic [2:0] digit;
    logic phase_step, slot_end, frame_wrap;
    disp_scan_timebase #(.PHASE_CYCLES(PHASE_CYCLES), .N_DIGITS(N_DIGITS)) u_timebase (
        .clock(clock),
        .reset(reset),
        .phase(phase),
        .digit(digit),
        .phase_step(phase_step),
        .slot_end(slot_end),
        .frame_wrap(frame_wrap)
    );
    scan_state_t state, state_nx;
    logic [31:0] shadow, pending;
    logic pending_full, wrap_q, lit;
    logic [3:0] phase_nx;
    assign value_ready = !pending_full;
    assign phase_nx = phase + 4'd1;
    // State always describes the phase the counters are currently in.
    always_comb begin
        state_nx = state;
        lit = 1'b0;
        if (phase_step)
            case (state)
                GAP: state_nx = bright != 4'd0 ? ON : OFF;
                ON: state_nx = slot_end ? GAP : (phase_nx > bright ? OFF : ON);
                default: state_nx = slot_end ? GAP : OFF;
            endcase
        if (state == ON && digit_en[digit])
            lit = !(lz_suppress && digit != 3'd0 && upper_zero(shadow, digit));
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= GAP;
            shadow <= 32'd0;
            pending <= 32'd0;
            pending_full <= 1'b0;
            wrap_q <= 1'b0;
            anodes <= 8'hFF;
            nibble <= 4'd0;
            digit_sel <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            if (value_valid && value_ready) begin
                pending <= value_in;
                pending_full <= 1'b1;
            end else if (frame_wrap && pending_full) begin
                shadow <= pending;
                pending_full <= 1'b0;
            end
            // Two stages so the pulse lines up with the first registered digit-0 output.
            wrap_q <= frame_wrap;
            frame_done <= wrap_q;
            anodes <= lit ? ~(8'd1 << digit) : 8'hFF;
            nibble <= nib(shadow, digit);
            digit_sel <= digit;
        end
    end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan scheduler for the 8-digit multiplexed 7-segment display.
- Owns frame timing: digit slots, anti-ghost blanking gap, brightness PWM, per-digit enable and leading-zero suppression.
- Accepts new 32-bit display words over a valid/ready handshake and swaps them in only at frame boundaries, so a frame never mixes two words.
- `nibble` drives the hex/BCD-to-segment decoder; `anodes` drive the board directly.

Parameters:
- PHASE_CYCLES, default 6250: clock cycles per PWM phase. Slot = 16 phases; frame = 8 slots. At 100 MHz, 1 frame = 8 ms.
- N_DIGITS, default 8: number of digits. Fixed at 8 in this revision; digit_sel width = 3.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- value_in, in, 32: display word. Nibble i feeds digit i.
- value_valid, in, 1: requester has a word on value_in.
- value_ready, out, 1: block can accept a word.
- digit_en, in, 8: per-digit enable mask. 0 = digit always dark.
- lz_suppress, in, 1: blank leading zero digits.
- bright, in, 4: lit phases per slot, 0..15.
- anodes, out, 8: active-low one-hot anode drive. 8'hFF = all dark.
- nibble, out, 4: value of the current digit, to the segment decoder.
- digit_sel, out, 3: index of the current digit.
- frame_done, out, 1: one-cycle pulse at the start of each frame.

Behaviour:
- Reset is asynchronous and active-high, and applies mid-operation. All of the following take effect immediately and the scan restarts at digit 0, phase 0 after release:
  - anodes = 8'hFF, nibble = 0, digit_sel = 0, frame_done = 0, value_ready = 1.
  - Shadow word = 0, pending buffer empty, all counters = 0.
- Counters:
  - pc counts 0..PHASE_CYCLES-1.
  - phase (0..15) increments when pc wraps.
  - digit_sel (0..7) increments when phase wraps from 15.
  - digit_sel wraps 7 -> 0.
- Frame boundary = the cycle in which digit_sel wraps 7 -> 0.
- Per-slot FSM, states GAP / ON / OFF:
  - GAP: phase 0. Anodes are always dark (ghost suppression).
  - GAP -> ON at phase 1 if bright >= 1; otherwise GAP -> OFF.
  - ON -> OFF when phase == bright + 1. ON lasts phases 1..bright.
  - OFF -> GAP when the phase counter wraps, i.e. at the next slot.
  - bright is sampled at each phase step. A mid-slot change takes effect at the next phase.
- Digit lit condition, for d = digit_sel: state == ON && digit_en[d] && !lz_blank(d).
  - lz_blank(d) = lz_suppress && d != 0 && shadow nibbles d..7 are all zero.
  - Digit 0 is never suppressed.
- Outputs are registered:
  - anodes = ~(1 << d) when the digit is lit, else 8'hFF.
  - nibble = shadow[4d+3:4d], updated every slot regardless of lit state.
  - Latency: 1 clock from counter state to outputs.
- Handshake:
  - value_ready = !pending_full.
  - Transfer on value_valid && value_ready: value_in is captured into pending and pending_full is set.
  - At the frame boundary with pending_full set: shadow <= pending and pending_full is cleared. value_ready rises the next cycle.
  - No transfer can coincide with the copy, because ready is low during it.
  - A requester holding value_valid while ready is low stalls. Its data must be held stable.
- frame_done is high for the first cycle of digit 0 slot 0, the cycle in which the new shadow is first visible.
- The word is latest-accepted-wins. At most one word waits in pending.

Decomposition:
- Package disp_pkg holds:
  - N_DIGITS = 8, N_PHASES = 16.
  - typedef scan_state_t enum {GAP, ON, OFF}.
  - typedef digit_idx_t logic [2:0].
- One sub-module, disp_scan_timebase: pc/phase/digit counters. It emits phase_step, slot_end and frame_wrap strobes.
- The top module holds the FSM, shadow/pending registers, the handshake, blanking logic and output registers.

Test Plan:
All tests use PHASE_CYCLES = 2, so slot = 32 cycles and frame = 256 cycles.
1. Reset check: assert reset, then release. Required: anodes = FF, nibble = 0, digit_sel = 0 and value_ready = 1 while reset is high and after release.
2. Display word: send 32'h89ABCDEF, bright = 15, digit_en = FF.
   - value_ready drops after the transfer and frame_done pulses at the next boundary.
   - Digit 0: nibble = F; anodes = FF for phase 0, FE for phases 1..15.
   - Digit 3: nibble = C, anodes = F7.
   - Digit 7: nibble = 8, anodes = 7F.
3. Brightness: bright = 4. Required: each slot has exactly 8 cycles with an anode low, during phases 1..4. With bright = 0, anodes stay FF for the whole frame.
4. Leading-zero suppression: word 32'h00000120, lz_suppress = 1.
   - Digits 0..2 lit with nibbles 0, 2, 1; digits 3..7 stay FF.
   - Word 0: only digit 0 lit.
   - digit_en = 8'hFD: digit 1 dark.
5. Handshake stall: send A = 32'h11111111, then hold valid with B = 32'h22222222 before the boundary.
   - Ready stays low until the boundary.
   - Shadow = A at frame_done.
   - B is accepted 1 cycle later and shown one frame after that.
6. Reset mid-frame: assert reset at digit 5, phase 7 while lit. Required: anodes = FF in the same cycle, shadow cleared, and after release the scan restarts at digit 0 with nibble = 0.
